multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore/Mealy FSM that sequences the 16-bit MIPS datapath as a multi-cycle machine: one shared ALU, one shared memory port, IR/A/B/ALUOut holding registers.
- Decodes the 4-bit opcode and drives per-cycle datapath enables and mux selects.
- Handles a req/ready handshake to a variable-latency unified memory.
- Sits beside the datapath as its only control source; replaces the single-cycle MainControl.

Parameters:
- MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before a fatal memory error (1..255).
- OP_W, 4, opcode width.
- ALUCTL_W, 4, ALU control width.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- opcode  in  OP_W  IR[15:12] from the IR register; valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, qualified by mem_req
- iord  out  1  address select: 0=PC, 1=ALUOut
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  load PC
- pc_source  out  1  PC input select: 0=ALU result, 1=ALUOut register
- reg_write  out  1  register file write enable
- reg_dst  out  1  write register select: 1=IR[7:6], 0=IR[9:8]
- mem_to_reg  out  1  write data select: 1=memory data register, 0=ALUOut
- alu_src_a  out  1  ALU A input: 0=PC, 1=A register
- alu_src_b  out  2  ALU B input: 00=B register, 01=constant 2, 10=sign-extended imm, 11=sign-extended imm<<1
- alu_ctl  out  ALUCTL_W  ALU control code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 NAND
- halted  out  1  FSM in HALT
- trap  out  1  illegal-opcode trap flag (see Optional Feature)

Behaviour:
Reset:
- Reset is asynchronous: state goes to IDLE and the timeout counter clears immediately.
- All outputs are 0 while reset_n is low and in IDLE.
- Reset during a pending memory access abandons that access; mem_req drops immediately.

States and transitions:
- IDLE: no outputs asserted. Goes to FETCH unconditionally on the next edge.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctl=ADD, pc_source=0.
  - ir_write and pc_write equal mem_ready (Mealy).
  - On mem_ready, go to DECODE; otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctl=ADD; this precomputes the branch target into ALUOut. Next state by opcode:
  - 0000–0110 to EXEC_R
  - 0111 to EXEC_I
  - 1000/1001 to MEM_ADDR
  - 1010/1011 to BRANCH
  - 1100–1111: illegal
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_ctl by opcode (0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 NOR, 0101 NAND, 0110 SLT). Goes to WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- EXEC_I (ADDI): alu_src_a=1, alu_src_b=10, ADD. Goes to WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Goes to MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_req=1, iord=1. Waits for mem_ready, then goes to WB_MEM.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1. Goes to FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1. Waits for mem_ready, then goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=1. Goes to FETCH.
  - BEQ: pc_write = zero.
  - BNE: pc_write = ~zero.
- HALT: all outputs 0 except halted=1 (and trap where applicable). Left only by reset.

Handshake:
- mem_req is held high until the cycle mem_ready=1; the access completes in that cycle.
- mem_ready is ignored when mem_req=0.
- mem_we and iord are stable for the whole request.

Timeout:
- An 8-bit counter clears on entry to each wait state and increments every cycle mem_ready=0.
- On reaching MEM_TIMEOUT, the FSM goes to HALT.

Latency with zero-wait memory:
- R-type/ADDI: 4 cycles.
- LW: 5 cycles.
- SW: 4 cycles.
- BEQ/BNE: 3 cycles.
- Each memory wait cycle adds 1.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: an illegal opcode in DECODE goes to HALT with trap=1 and halted=1, both held until reset.
- Undefined: an illegal opcode is a NOP (DECODE to FETCH) and trap is tied 0.

Decomposition:
- Package cpu16_pkg holds:
  - opcode constants
  - ALU control codes
  - state encoding (4-bit)
  - alu_src_b select codes
- Sub-module alu_ctl_decode: combinational opcode-to-alu_ctl map, used in EXEC_R.

Test Plan:
- Zero-wait ADD (opcode 0000): states IDLE, FETCH, DECODE, EXEC_R, WB_R, FETCH; reg_write=1 for exactly 1 cycle with reg_dst=1; pc_write only in FETCH.
- LW with mem_ready delayed 3 cycles in MEM_RD: mem_req held 4 cycles with iord=1, mem_we=0; WB_MEM has mem_to_reg=1; total 8 cycles.
- BEQ with zero=1 gives pc_write=1 and pc_source=1 in BRANCH; BNE with zero=1 gives pc_write=0; both return to FETCH.
- mem_ready held low in FETCH with MEM_TIMEOUT=16: after 16 wait cycles halted=1, mem_req=0, and it stays halted until reset_n pulses low.
- reset_n asserted mid-MEM_WR: mem_req/mem_we drop within the same cycle (async); after release, IDLE then FETCH.
- Opcode 1110: with ILLEGAL_OP_TRAP_EN, trap=1 and halted=1 after DECODE; without it, FETCH follows DECODE and trap=0.

Source files
------------

// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit multi-cycle CPU control path: opcodes, ALU codes,
// ALU B-input selects, FSM state encoding and the per-state control word.
package cpu16_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_ADDI = 4'b0111;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_BNE  = 4'b1011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_TWO    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       pc_source;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctl;
        logic       halted;
    } ctl_t;

    // Moore part of the control word for a state; r_alu is only used in EXEC_R.
    function automatic ctl_t state_outputs(state_t s, logic [3:0] r_alu);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = SRCB_TWO;
                c.alu_ctl   = ALU_ADD;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_IMM_SH;
                c.alu_ctl   = ALU_ADD;
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_ctl   = r_alu;
            end
            S_WB_R: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_ctl   = ALU_ADD;
            end
            S_WB_I: c.reg_write = 1'b1;
            S_MEM_RD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.iord    = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_ctl   = ALU_SUB;
                c.pc_source = 1'b1;
            end
            S_HALT:  c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational map from R-type opcode to ALU control code.
module alu_ctl_decode
    import cpu16_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [3:0] alu_ctl
);

    always_comb begin
        alu_ctl = ALU_ADD;
        case (opcode)
            OP_ADD:  alu_ctl = ALU_ADD;
            OP_SUB:  alu_ctl = ALU_SUB;
            OP_AND:  alu_ctl = ALU_AND;
            OP_OR:   alu_ctl = ALU_OR;
            OP_NOR:  alu_ctl = ALU_NOR;
            OP_NAND: alu_ctl = ALU_NAND;
            OP_SLT:  alu_ctl = ALU_SLT;
            default: alu_ctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit MIPS datapath with a req/ready memory handshake.
// Build option ILLEGAL_OP_TRAP_EN: illegal opcodes halt with trap=1 instead of acting as NOPs.
//
// state    | meaning
// IDLE     | after reset, nothing asserted
// FETCH    | read instruction at PC, PC += 2 on completion
// DECODE   | precompute branch target into ALUOut
// EXEC_R   | R-type ALU operation on A, B
// WB_R     | write ALUOut to IR[7:6]
// EXEC_I   | ADDI: A + imm
// WB_I     | write ALUOut to IR[9:8]
// MEM_ADDR | LW/SW address A + imm
// MEM_RD   | load access, waits on mem_ready
// WB_MEM   | write loaded data to IR[9:8]
// MEM_WR   | store access, waits on mem_ready
// BRANCH   | compare A - B, conditional PC load from ALUOut
// HALT     | stopped until reset (timeout or trap)
module multicycle_ctrl
    import cpu16_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int OP_W        = 4,
    parameter int ALUCTL_W    = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [OP_W-1:0]     opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_source,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUCTL_W-1:0] alu_ctl,
    output logic                halted,
    output logic                trap
);

    state_t     state;
    state_t     nxt;
    ctl_t       ctl_q;
    logic [7:0] wait_cnt;
    logic [3:0] op;
    logic [3:0] r_alu;
    logic       wait_st;
    logic       timed_out;

    assign op = opcode[3:0];

    alu_ctl_decode u_alu_ctl_decode (
        .opcode  (op),
        .alu_ctl (r_alu)
    );

    assign wait_st   = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign timed_out = !mem_ready && (wait_cnt == 8'(MEM_TIMEOUT - 1));

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      nxt = S_DECODE;
                else if (timed_out) nxt = S_HALT;
            end
            S_DECODE: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_NOR, OP_NAND, OP_SLT: nxt = S_EXEC_R;
                    OP_ADDI:                 nxt = S_EXEC_I;
                    OP_LW, OP_SW:            nxt = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:          nxt = S_BRANCH;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:                 nxt = S_HALT;
`else
                    default:                 nxt = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R:   nxt = S_WB_R;
            S_WB_R:     nxt = S_FETCH;
            S_EXEC_I:   nxt = S_WB_I;
            S_WB_I:     nxt = S_FETCH;
            S_MEM_ADDR: nxt = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)      nxt = S_WB_MEM;
                else if (timed_out) nxt = S_HALT;
            end
            S_WB_MEM:   nxt = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready)      nxt = S_FETCH;
                else if (timed_out) nxt = S_HALT;
            end
            S_BRANCH:   nxt = S_FETCH;
            S_HALT:     nxt = S_HALT;
            default:    nxt = S_IDLE;
        endcase
    end

    // Control word is registered for the state being entered, so outputs clear with the async reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            ctl_q    <= '0;
            wait_cnt <= '0;
        end else begin
            state <= nxt;
            ctl_q <= state_outputs(nxt, r_alu);
            if (wait_st && !mem_ready && (nxt == state))
                wait_cnt <= wait_cnt + 8'd1;
            else
                wait_cnt <= '0;
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic trap_q;

    // HALT is reachable from DECODE only through an illegal opcode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            trap_q <= 1'b0;
        else if ((state == S_DECODE) && (nxt == S_HALT))
            trap_q <= 1'b1;
    end

    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    assign ir_write = (state == S_FETCH) && mem_ready;
    assign pc_write = ((state == S_FETCH) && mem_ready) ||
                      ((state == S_BRANCH) && ((op == OP_BNE) ? !zero : zero));

    assign mem_req    = ctl_q.mem_req;
    assign mem_we     = ctl_q.mem_we;
    assign iord       = ctl_q.iord;
    assign pc_source  = ctl_q.pc_source;
    assign reg_write  = ctl_q.reg_write;
    assign reg_dst    = ctl_q.reg_dst;
    assign mem_to_reg = ctl_q.mem_to_reg;
    assign alu_src_a  = ctl_q.alu_src_a;
    assign alu_src_b  = ctl_q.alu_src_b;
    assign alu_ctl    = ALUCTL_W'(ctl_q.alu_ctl);
    assign halted     = ctl_q.halted;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output vectors compared against hand-built tables.
module tb_multicycle_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_source;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctl;
    logic       halted, trap;

    int checks = 0;
    int errors = 0;

    // {req we iord irw pcw pcs rw rd m2r asa}_{alu_src_b}_{alu_ctl}_{halted trap}
    localparam logic [17:0] V_IDLE       = 18'b0000000000_00_0000_00;
    localparam logic [17:0] V_FETCH_RDY  = 18'b1001100000_01_0010_00;
    localparam logic [17:0] V_FETCH_WAIT = 18'b1000000000_01_0010_00;
    localparam logic [17:0] V_DECODE     = 18'b0000000000_11_0010_00;
    localparam logic [17:0] V_EXR_BASE   = 18'b0000000001_00_0000_00;
    localparam logic [17:0] V_WB_R       = 18'b0000001100_00_0000_00;
    localparam logic [17:0] V_EX_IMM     = 18'b0000000001_10_0010_00;
    localparam logic [17:0] V_WB_I       = 18'b0000001000_00_0000_00;
    localparam logic [17:0] V_MEM_RD     = 18'b1010000000_00_0000_00;
    localparam logic [17:0] V_WB_MEM     = 18'b0000001010_00_0000_00;
    localparam logic [17:0] V_MEM_WR     = 18'b1110000000_00_0000_00;
    localparam logic [17:0] V_BR_T       = 18'b0000110001_00_0110_00;
    localparam logic [17:0] V_BR_NT      = 18'b0000010001_00_0110_00;
    localparam logic [17:0] V_HALT       = 18'b0000000000_00_0000_10;
    localparam logic [17:0] V_HALT_T     = 18'b0000000000_00_0000_11;

    multicycle_ctrl #(.MEM_TIMEOUT(16), .OP_W(4), .ALUCTL_W(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctl    (alu_ctl),
        .halted     (halted),
        .trap       (trap)
    );

    always #5 clock = ~clock;

    function automatic logic [17:0] obs();
        return {mem_req, mem_we, iord, ir_write, pc_write, pc_source, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, alu_ctl, halted, trap};
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; opcode = 4'b0000; zero = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            #1;
            checks++;
            if (obs() !== V_IDLE) begin
                errors++;
                $display("FAIL reset cyc%0d: got %b expected %b", i, obs(), V_IDLE);
            end
        end
        next_cycle();
        reset_n = 1'b1; zero = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_add();
        logic [17:0] ex [6];
        logic        rd [6];
        ex = '{V_IDLE, V_FETCH_RDY, V_DECODE, V_EXR_BASE | 18'b10_00, V_WB_R, V_FETCH_WAIT};
        rd = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        opcode = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rd[i];
            #1;
            checks++;
            if (obs() !== ex[i]) begin
                errors++;
                $display("FAIL add cyc%0d: got %b expected %b", i, obs(), ex[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_alu_map();
        logic [3:0] ops  [4];
        logic [3:0] alus [4];
        logic [17:0] ex  [5];
        ops  = '{4'b0001, 4'b0101, 4'b0110, 4'b0100};
        alus = '{4'b0110, 4'b1101, 4'b0111, 4'b1100};
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k];
            ex = '{V_FETCH_RDY, V_DECODE, V_EXR_BASE | {12'd0, alus[k], 2'b00}, V_WB_R, V_FETCH_WAIT};
            for (int i = 0; i < 5; i++) begin
                mem_ready = (i == 0);
                #1;
                checks++;
                if (obs() !== ex[i]) begin
                    errors++;
                    $display("FAIL alu_map op%b cyc%0d: got %b expected %b", ops[k], i, obs(), ex[i]);
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_addi();
        logic [17:0] ex [5];
        ex = '{V_FETCH_RDY, V_DECODE, V_EX_IMM, V_WB_I, V_FETCH_WAIT};
        opcode = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i == 0);
            #1;
            checks++;
            if (obs() !== ex[i]) begin
                errors++;
                $display("FAIL addi cyc%0d: got %b expected %b", i, obs(), ex[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_lw_wait();
        logic [17:0] ex [9];
        logic        rd [9];
        ex = '{V_FETCH_RDY, V_DECODE, V_EX_IMM, V_MEM_RD, V_MEM_RD, V_MEM_RD, V_MEM_RD,
               V_WB_MEM, V_FETCH_WAIT};
        rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        opcode = 4'b1000;
        for (int i = 0; i < 9; i++) begin
            mem_ready = rd[i];
            #1;
            checks++;
            if (obs() !== ex[i]) begin
                errors++;
                $display("FAIL lw_wait cyc%0d: got %b expected %b", i, obs(), ex[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_sw();
        logic [17:0] ex [5];
        ex = '{V_FETCH_RDY, V_DECODE, V_EX_IMM, V_MEM_WR, V_FETCH_WAIT};
        opcode = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i == 0) || (i == 3);
            #1;
            checks++;
            if (obs() !== ex[i]) begin
                errors++;
                $display("FAIL sw cyc%0d: got %b expected %b", i, obs(), ex[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_branch();
        logic [3:0]  ops [4];
        logic        zs  [4];
        logic [17:0] brs [4];
        logic [17:0] ex  [4];
        ops = '{4'b1010, 4'b1011, 4'b1010, 4'b1011};
        zs  = '{1'b1, 1'b1, 1'b0, 1'b0};
        brs = '{V_BR_T, V_BR_NT, V_BR_NT, V_BR_T};
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k];
            zero   = zs[k];
            ex = '{V_FETCH_RDY, V_DECODE, brs[k], V_FETCH_WAIT};
            for (int i = 0; i < 4; i++) begin
                mem_ready = (i == 0);
                #1;
                checks++;
                if (obs() !== ex[i]) begin
                    errors++;
                    $display("FAIL branch op%b z%0b cyc%0d: got %b expected %b",
                             ops[k], zs[k], i, obs(), ex[i]);
                end
                next_cycle();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_reset_mid_wr();
        logic [17:0] ex [5];
        ex = '{V_FETCH_RDY, V_DECODE, V_EX_IMM, V_MEM_WR, V_MEM_WR};
        opcode = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i < 3);
            #1;
            checks++;
            if (obs() !== ex[i]) begin
                errors++;
                $display("FAIL mid_wr cyc%0d: got %b expected %b", i, obs(), ex[i]);
            end
            if (i < 4) next_cycle();
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we} !== 2'b00) begin
            errors++;
            $display("FAIL mid_wr async drop: got req/we %b expected 00", {mem_req, mem_we});
        end
        next_cycle();
        reset_n = 1'b1;
        #1;
        checks++;
        if (obs() !== V_IDLE) begin
            errors++;
            $display("FAIL mid_wr idle: got %b expected %b", obs(), V_IDLE);
        end
        next_cycle();
        mem_ready = 1'b0;
        #1;
        checks++;
        if (obs() !== V_FETCH_WAIT) begin
            errors++;
            $display("FAIL mid_wr fetch: got %b expected %b", obs(), V_FETCH_WAIT);
        end
        next_cycle();
    endtask

    task automatic test_illegal();
`ifdef ILLEGAL_OP_TRAP_EN
        logic [17:0] ex [4];
        ex = '{V_FETCH_RDY, V_DECODE, V_HALT_T, V_HALT_T};
`else
        logic [17:0] ex [4];
        ex = '{V_FETCH_RDY, V_DECODE, V_FETCH_WAIT, V_FETCH_WAIT};
`endif
        opcode = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 0);
            #1;
            checks++;
            if (obs() !== ex[i]) begin
                errors++;
                $display("FAIL illegal cyc%0d: got %b expected %b", i, obs(), ex[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_timeout();
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        opcode = 4'b0000;
        for (int i = 0; i < 22; i++) begin
            logic [17:0] e;
            e = (i == 0) ? V_IDLE : (i <= 16) ? V_FETCH_WAIT : V_HALT;
            mem_ready = (i > 17) ? i[0] : 1'b0;
            #1;
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL timeout cyc%0d: got %b expected %b", i, obs(), e);
            end
            next_cycle();
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs() !== V_IDLE) begin
            errors++;
            $display("FAIL timeout reset: got %b expected %b", obs(), V_IDLE);
        end
        next_cycle();
        reset_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (obs() !== V_IDLE) begin
            errors++;
            $display("FAIL timeout idle: got %b expected %b", obs(), V_IDLE);
        end
        next_cycle();
        mem_ready = 1'b1;
        #1;
        checks++;
        if (obs() !== V_FETCH_RDY) begin
            errors++;
            $display("FAIL timeout refetch: got %b expected %b", obs(), V_FETCH_RDY);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_alu_map();
        test_addi();
        test_lw_wait();
        test_sw();
        test_branch();
        test_reset_mid_wr();
        test_illegal();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
